mac_tx_arbiter: RTL
===================

# mac_tx_arbiter

Transmit scheduler for the MAC, sitting between the frame sources (ARP reply encoder, IP transmit path) and the RGMII PHY interface. It grants the single nibble-wide TX datapath to one source per frame using round-robin arbitration, forwards that source's nibbles to the PHY interface, and paces the PHY interface's `send_next` consumption strobe back to the granted source. Between frames it enforces the inter-frame gap, and it terminates frames that underrun or exceed the maximum length.

## Interface
Parameters:
- `IFG_NIBBLES`, 24: idle cycles between frames (96 bit times at 100 Mb/s).
- `MAX_NIBBLES`, 3036: maximum nibbles per frame (1518 bytes) before forced termination.

Ports:
- `clk_25mhz`  in  1  system clock; reset `rst` is synchronous, active-high.
- `rst`  in  1  synchronous active-high reset.
- `arp_req`  in  1  ARP source has a frame pending.
- `arp_gnt`  out  1  ARP source owns the TX path.
- `arp_valid`  in  1  `arp_d` holds a valid nibble.
- `arp_d`  in  4  ARP nibble, low nibble first.
- `arp_last`  in  1  current ARP nibble is the final one.
- `arp_ready`  out  1  the current ARP nibble is consumed this cycle.
- `ip_req`, `ip_gnt`, `ip_valid`, `ip_d`, `ip_last`, `ip_ready`: same as the ARP set, for the IP source.
- `mac_phy_txen`  out  1  frame enable to the PHY interface.
- `mac_phy_txd`  out  4  nibble to the PHY interface.
- `send_next`  in  1  PHY interface consumes `mac_phy_txd` this cycle.
- `busy`  out  1  state is not IDLE.
- `underrun_err`  out  1  one-cycle pulse: granted source dropped valid mid-frame.
- `oversize_err`  out  1  one-cycle pulse: frame reached `MAX_NIBBLES` without last.

## Operation
- States: IDLE, GRANT, SEND, IFG.
- **IDLE**
  - If exactly one `*_req` is high, register a grant to that source and go to GRANT.
  - If both are high, grant the source selected by the round-robin pointer `rr` (0 = ARP, 1 = IP).
- **GRANT**
  - The selected `*_gnt` is high.
  - If the source's `req` drops before `valid`, go to IDLE with no frame sent and `rr` unchanged.
  - If `valid` is high, go to SEND.
- **SEND**
  - `mac_phy_txen`=1.
  - `mac_phy_txd` is combinationally muxed from the granted `*_d`.
  - The granted `*_ready` equals `send_next & *_valid`.
  - Each accepted nibble increments the 12-bit counter `nib_cnt`.
  - Accepted nibble with `last` set: go to IFG.
  - `valid`=0 while `txen`=1: pulse `underrun_err` and go to IFG. `txen` drops the next cycle, which truncates the frame so the FCS fails at the far end.
  - Acceptance that makes `nib_cnt`==`MAX_NIBBLES` without `last`: pulse `oversize_err` and go to IFG.
  - On every exit from SEND, set `rr` to the other source and deassert `gnt`.
- **IFG**
  - `txen`=0, `txd`=0.
  - The counter counts `IFG_NIBBLES` cycles, then the block returns to IDLE.
  - Requests are ignored until IDLE.
- A `req` that toggles on a non-granted source has no effect.
- Outputs `*_gnt`, `*_ready` and `mac_phy_txd` are 0 for the non-granted source.

## Timing
- Reset values:
  - State IDLE, `rr`=0 (ARP first), counters 0.
  - All outputs 0: `gnt`, `ready`, `txen`, `txd`, `busy`, error pulses.
- Reset mid-frame: `txen` is 0 in the cycle after `rst` is sampled. No IFG is applied after reset.
- Latency:
  - `req` seen in IDLE at cycle N gives `gnt` at cycle N+1.
  - `valid` seen in GRANT at cycle N+1 gives `txen` at cycle N+2.
- `txd`/`ready` are combinational from the granted source and `send_next`. `txen`, `gnt` and `busy` are registered.
- The final nibble is accepted at cycle M. `txen` is 0 from M+1, and IFG covers M+1 through M+`IFG_NIBBLES`. The earliest next `gnt` is at M+`IFG_NIBBLES`+2.
- Priority of events on the same SEND cycle: `rst` > underrun > last > oversize.
- `nib_cnt` clears on entry to SEND and must not wrap; the width must hold `MAX_NIBBLES`.

## Structure
- Package `mac_pkg`, shared with the other MAC blocks, contains:
  - `tx_state_t` enum (IDLE, GRANT, SEND, IFG);
  - `SRC_ARP`/`SRC_IP` index constants;
  - defaults for `IFG_NIBBLES` and `MAX_NIBBLES`.
- Sub-module `rr_arb2`: a two-requester round-robin picker with `req[1:0]`, `rr` and `pick` ports, plus a registered pointer update on an `advance` strobe.

## Test plan
- ARP only: `arp_req`=1, a 28-nibble frame with `send_next`=1 every cycle.
  - `gnt` after 1 cycle, `txen` after 2.
  - 28 nibbles appear on `txd` in order.
  - `txen` is low for exactly 24 cycles before IDLE.
- Both `req` high out of reset:
  - ARP is served first, then IP after the IFG.
  - With both still requesting, IP then ARP alternate across 4 frames.
- `send_next` pattern 1,0,0,1:
  - `arp_ready` is high only on the `send_next` cycles.
  - `nib_cnt` advances only on those cycles, and `txd` is stable in between.
- Underrun: IP `valid` drops after 10 nibbles.
  - `underrun_err` pulses once.
  - `txen` is 0 the next cycle, then 24 IFG cycles follow.
  - `rr` selects ARP next.
- Oversize: the source never asserts `last`.
  - `oversize_err` pulses at nibble 3036.
  - `txen` drops and `gnt` deasserts.
- `rst` asserted mid-SEND, and `req` dropped during GRANT:
  - Mid-SEND reset: all outputs are 0 the next cycle, and ARP is served first afterwards.
  - Dropped `req`: return to IDLE with no `txen` pulse.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC definitions: TX scheduler states, source indices
// and frame-timing defaults.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SEND,
    IFG
  } tx_state_t;

  localparam logic SRC_ARP = 1'b0;
  localparam logic SRC_IP  = 1'b1;

  localparam int IFG_NIBBLES_DEF = 24;
  localparam int MAX_NIBBLES_DEF = 3036;
  localparam int NIB_W           = 12;

endpackage

// File: rtl/mac_tx_arbiter_rr_arb2.sv
// Two-requester round-robin picker; the pointer moves to the
// source that was not just served.
module rr_arb2
  import mac_pkg::*;
(
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic       rr,
  output logic       pick
);

  always_comb begin
    pick = rr;
    unique case (req)
      2'b01:   pick = SRC_ARP;
      2'b10:   pick = SRC_IP;
      default: pick = rr;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      rr <= SRC_ARP;
    end else if (advance) begin
      rr <= ~served;
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// TX scheduler: grants the nibble datapath to ARP or IP per frame,
// paces send_next back to the owner and enforces the inter-frame gap.
module mac_tx_arbiter
  import mac_pkg::*;
#(
  parameter int IFG_NIBBLES = IFG_NIBBLES_DEF,
  parameter int MAX_NIBBLES = MAX_NIBBLES_DEF
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic       arp_req,
  output logic       arp_gnt,
  input  logic       arp_valid,
  input  logic [3:0] arp_d,
  input  logic       arp_last,
  output logic       arp_ready,
  input  logic       ip_req,
  output logic       ip_gnt,
  input  logic       ip_valid,
  input  logic [3:0] ip_d,
  input  logic       ip_last,
  output logic       ip_ready,
  output logic       mac_phy_txen,
  output logic [3:0] mac_phy_txd,
  input  logic       send_next,
  output logic       busy,
  output logic       underrun_err,
  output logic       oversize_err
);

  localparam int IFG_W = $clog2(IFG_NIBBLES + 1);

  tx_state_t        state;
  logic             src;
  logic             gnt;
  logic [NIB_W-1:0] nib_cnt;
  logic [IFG_W-1:0] ifg_cnt;

  logic [1:0] req_v;
  logic       pick;
  logic       rr_unused;
  logic       s_req;
  logic       s_valid;
  logic       s_last;
  logic [3:0] s_d;
  logic       s_acc;
  logic       und;
  logic       done;
  logic       ovs;
  logic       fin;
  logic       advance;

  assign req_v = {ip_req, arp_req};

  always_comb begin
    s_req   = arp_req;
    s_valid = arp_valid;
    s_last  = arp_last;
    s_d     = arp_d;
    if (src == SRC_IP) begin
      s_req   = ip_req;
      s_valid = ip_valid;
      s_last  = ip_last;
      s_d     = ip_d;
    end
  end

  assign s_acc = mac_phy_txen & send_next & s_valid;

  // underrun wins over last, last wins over oversize
  assign und  = (state == SEND) & ~s_valid;
  assign done = (state == SEND) & s_acc & s_last;
  assign ovs  = (state == SEND) & s_acc & ~s_last
              & (nib_cnt == NIB_W'(MAX_NIBBLES - 1));
  assign fin  = und | done | ovs;

  assign advance = fin;

  assign arp_gnt     = gnt & (src == SRC_ARP);
  assign ip_gnt      = gnt & (src == SRC_IP);
  assign arp_ready   = s_acc & (src == SRC_ARP);
  assign ip_ready    = s_acc & (src == SRC_IP);
  assign mac_phy_txd = mac_phy_txen ? s_d : 4'h0;

  rr_arb2 u_arb (
    .clk_25mhz (clk_25mhz),
    .rst       (rst),
    .req       (req_v),
    .advance   (advance),
    .served    (src),
    .rr        (rr_unused),
    .pick      (pick)
  );

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      state        <= IDLE;
      src          <= SRC_ARP;
      gnt          <= 1'b0;
      mac_phy_txen <= 1'b0;
      busy         <= 1'b0;
      nib_cnt      <= '0;
      ifg_cnt      <= '0;
      underrun_err <= 1'b0;
      oversize_err <= 1'b0;
    end else begin
      underrun_err <= 1'b0;
      oversize_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req_v) begin
            src   <= pick;
            gnt   <= 1'b1;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (s_valid) begin
            mac_phy_txen <= 1'b1;
            nib_cnt      <= '0;
            state        <= SEND;
          end else if (!s_req) begin
            gnt   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SEND: begin
          if (s_acc) begin
            nib_cnt <= nib_cnt + 1'b1;
          end
          if (fin) begin
            mac_phy_txen <= 1'b0;
            gnt          <= 1'b0;
            ifg_cnt      <= '0;
            underrun_err <= und;
            oversize_err <= ovs;
            state        <= IFG;
          end
        end
        IFG: begin
          if (ifg_cnt == IFG_W'(IFG_NIBBLES - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
